loc_walker: RTL and testbench

- Raster location generator that sits directly upstream of the sim-state controller.
- Walks every screen location in raster order, x fastest, then y.
- Drives two outputs:
  - the write location consumed by the controller and the envCache write port;
  - a read location that runs PIPE_DEPTH positions ahead, feeding the envCache read pipeline.
- Freezes whenever the controller asserts hold_locs, so exactly one full walk-through happens per game step.

---
 rtl/loc_walker.sv | 82 ++++++++
 tb/tb_loc_walker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/loc_walker.sv
// Raster location walker: produces the write location and a read location that runs
// PIPE_DEPTH raster positions ahead, advancing once per clock unless held.
module loc_walker #(
    parameter int PIXELS_X   = 640,
    parameter int PIXELS_Y   = 480,
    parameter int X_bits     = 10,
    parameter int Y_bits     = 9,
    parameter int PIPE_DEPTH = 2,
    parameter int FC_bits    = 16
) (
    input  logic               newLocClock,
    input  logic               RUN,
    input  logic               hold_locs,
    output logic [X_bits-1:0]  writeLoc_x,
    output logic [Y_bits-1:0]  writeLoc_y,
    output logic [X_bits-1:0]  readLoc_x,
    output logic [Y_bits-1:0]  readLoc_y,
    output logic               frame_done,
    output logic [FC_bits-1:0] frame_count
);

    // Entry 0 is the read location, entry PIPE_DEPTH the write location; between them
    // sit the delay stages, each one raster position behind the entry before it.
    logic [X_bits-1:0] loc_x_p [0:PIPE_DEPTH];
    logic [Y_bits-1:0] loc_y_p [0:PIPE_DEPTH];
    logic [X_bits-1:0] step_x;
    logic [Y_bits-1:0] step_y;
    logic              at_bottom_right;

    function automatic logic [X_bits+Y_bits-1:0] raster_step(
        input logic [X_bits-1:0] x,
        input logic [Y_bits-1:0] y
    );
        logic [X_bits-1:0] nx;
        logic [Y_bits-1:0] ny;
        nx = x + 1'b1;
        ny = y;
        if (x == X_bits'(PIXELS_X - 1)) begin
            nx = '0;
            ny = (y == Y_bits'(PIXELS_Y - 1)) ? '0 : y + 1'b1;
        end
        return {nx, ny};
    endfunction

    assign {step_x, step_y} = raster_step(loc_x_p[0], loc_y_p[0]);

    assign at_bottom_right = (loc_x_p[PIPE_DEPTH] == X_bits'(PIXELS_X - 1)) &&
                             (loc_y_p[PIPE_DEPTH] == Y_bits'(PIXELS_Y - 1));

    // Stage boundary: read location, delay stages and write location all move together.
    always_ff @(posedge newLocClock or negedge RUN) begin
        if (!RUN) begin
            // PIPE_DEPTH < PIXELS_X, so every primed raster index lies on row 0.
            for (int k = 0; k <= PIPE_DEPTH; k++) begin
                loc_x_p[k] <= X_bits'(PIPE_DEPTH - k);
                loc_y_p[k] <= '0;
            end
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (!hold_locs) begin
                loc_x_p[0] <= step_x;
                loc_y_p[0] <= step_y;
                for (int k = 1; k <= PIPE_DEPTH; k++) begin
                    loc_x_p[k] <= loc_x_p[k-1];
                    loc_y_p[k] <= loc_y_p[k-1];
                end
                if (at_bottom_right) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

    assign writeLoc_x = loc_x_p[PIPE_DEPTH];
    assign writeLoc_y = loc_y_p[PIPE_DEPTH];
    assign readLoc_x  = loc_x_p[0];
    assign readLoc_y  = loc_y_p[0];

endmodule

// File: tb/tb_loc_walker.sv
// Directed bench for loc_walker on a 4x3 screen with a two-position read-ahead and a
// 3-bit frame counter; a raster-index model feeds an expectation queue each clock.
module tb_loc_walker;

    localparam int PX = 4;
    localparam int PY = 3;
    localparam int PD = 2;
    localparam int NLOC = PX * PY;

    logic       newLocClock = 1'b0;
    logic       RUN = 1'b1;
    logic       hold_locs = 1'b0;
    logic [1:0] writeLoc_x, readLoc_x;
    logic [1:0] writeLoc_y, readLoc_y;
    logic       frame_done;
    logic [2:0] frame_count;

    int passed = 0;
    int total  = 0;

    // Model state: write raster index, frame count, expected pulse.
    int m_widx = 0;
    int m_fc   = 0;
    int m_fd   = 0;
    logic [11:0] exp_q [$];

    loc_walker #(
        .PIXELS_X(PX), .PIXELS_Y(PY), .X_bits(2), .Y_bits(2),
        .PIPE_DEPTH(PD), .FC_bits(3)
    ) dut (
        .newLocClock(newLocClock),
        .RUN(RUN),
        .hold_locs(hold_locs),
        .writeLoc_x(writeLoc_x),
        .writeLoc_y(writeLoc_y),
        .readLoc_x(readLoc_x),
        .readLoc_y(readLoc_y),
        .frame_done(frame_done),
        .frame_count(frame_count)
    );

    always #5 newLocClock = ~newLocClock;

    function automatic logic [11:0] model_vec();
        int ridx;
        ridx = (m_widx + PD) % NLOC;
        return {2'(m_widx % PX), 2'(m_widx / PX), 2'(ridx % PX), 2'(ridx / PX),
                1'(m_fd), 3'(m_fc)};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {writeLoc_x, writeLoc_y, readLoc_x, readLoc_y, frame_done, frame_count};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chkloc(input string tag, input int wx, input int wy, input int rx, input int ry);
        chk(tag, {writeLoc_x, writeLoc_y, readLoc_x, readLoc_y},
            {2'(wx), 2'(wy), 2'(rx), 2'(ry)});
    endtask

    task automatic model_reset();
        m_widx = 0;
        m_fc   = 0;
        m_fd   = 0;
    endtask

    // Drive hold for the next edge, queue the expected post-edge state, then compare.
    task automatic step(input logic h);
        logic [11:0] e;
        hold_locs = h;
        if (!h) begin
            m_fd = (m_widx == NLOC - 1) ? 1 : 0;
            if (m_fd == 1) m_fc = (m_fc + 1) % 8;
            m_widx = (m_widx + 1) % NLOC;
        end else begin
            m_fd = 0;
        end
        exp_q.push_back(model_vec());
        @(posedge newLocClock);
        #1;
        e = exp_q.pop_front();
        chk("step", 32'(dut_vec()), 32'(e));
    endtask

    initial begin
        // Reset takes effect with no clock edge.
        #1 RUN = 1'b0;
        #2;
        model_reset();
        chk("reset_async", 32'(dut_vec()), 32'(model_vec()));
        chkloc("reset_loc", 0, 0, 2, 0);
        @(posedge newLocClock);
        #1;
        chk("reset_held", 32'(dut_vec()), 32'(model_vec()));
        RUN = 1'b1;

        // Free run.
        step(1'b0); chkloc("free1", 1, 0, 3, 0);
        step(1'b0); chkloc("free2", 2, 0, 0, 1);
        step(1'b0);
        step(1'b0); chkloc("free4", 0, 1, 2, 1);

        // Hold mid-frame at write (1,1).
        step(1'b0); chkloc("pre_hold", 1, 1, 3, 1);
        repeat (5) begin
            step(1'b1);
            chkloc("hold", 1, 1, 3, 1);
            chk("hold_fd", 32'(frame_done), 32'd0);
        end
        step(1'b0); chkloc("hold_rel", 2, 1, 0, 2);

        // Reach bottom-right, hold there, then wrap.
        repeat (5) step(1'b0);
        chkloc("bottom_right", 3, 2, 1, 0);
        repeat (3) begin
            step(1'b1);
            chkloc("br_hold", 3, 2, 1, 0);
            chk("br_hold_fd", 32'(frame_done), 32'd0);
        end
        step(1'b0);
        chkloc("wrap", 0, 0, 2, 0);
        chk("wrap_fd", 32'(frame_done), 32'd1);
        chk("wrap_fc", 32'(frame_count), 32'd1);
        step(1'b0);
        chk("wrap_fd_drop", 32'(frame_done), 32'd0);
        repeat (11) step(1'b0);
        chk("fc2", 32'(frame_count), 32'd2);

        // Asynchronous reset mid-frame at write (2,1) with frame_count 3.
        repeat (18) step(1'b0);
        chkloc("pre_reset", 2, 1, 0, 2);
        chk("pre_reset_fc", 32'(frame_count), 32'd3);
        #1 RUN = 1'b0;
        #1;
        model_reset();
        chk("async_reset", 32'(dut_vec()), 32'(model_vec()));
        @(posedge newLocClock);
        #1;
        chk("reset_low_edge", 32'(dut_vec()), 32'(model_vec()));
        RUN = 1'b1;
        step(1'b0); chkloc("post_reset", 1, 0, 3, 0);

        // Eight full frames roll the 3-bit frame counter back to zero.
        repeat (8 * NLOC) step(1'b0);
        chk("fc_wrap", 32'(frame_count), 32'd0);
        chkloc("fc_wrap_loc", 1, 0, 3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
